line_draw_scheduler: RTL and testbench
======================================

Name: line_draw_scheduler

Overview:
Sequencer that replaces hand-timed bench stimulus for the line pipeline: ROM2RAM load, per-line RAM fetch, B_Line start/finish handshake, then hand-off of the video buffer to Vga_Sync scan-out. It owns the single video-buffer port, multiplexing line-drawer writes and scan-out reads. It sits between ROM2RAM, B_Line, video_buffer and Vga_Sync at the top level.

Parameters:
ADDR_W, 8, RAM line-table address width; one address holds one line as four 32-bit words (x1, y1, x2, y2).
RAM_LAT, 1, cycles from ram_read_addr change to valid ram_read_data1..4.
XW, 10, pixel X width.
YW, 9, pixel Y width; vb_addr width is XW+YW.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to (re)build the frame
num_lines  in  ADDR_W+1  number of lines to draw, sampled on start
load_start  out  1  one-cycle pulse to ROM2RAM start
load_finish  in  1  ROM2RAM finish
ram_read_addr  out  ADDR_W  line-table index
ram_read_data1..4  in  32 each  x1, y1, x2, y2
x1, y1, x2, y2  out  32 each  registered endpoints to B_Line
line_start  out  1  one-cycle pulse to B_Line
line_finish  in  1  B_Line finish
line_x  in  XW  B_Line X
line_y  in  YW  B_Line Y
pix_x, pix_y  in  10 each  Vga_Sync pixel counters
scan_reset  out  1  active-high reset to Vga_Sync
vb_we  out  1  video-buffer write enable
vb_addr  out  XW+YW  video-buffer address
vb_wr_data  out  1  video-buffer write data
busy  out  1  sequence in progress
done  out  1  frame built, scan-out running

Behaviour:
- Reset values: load_start=0, line_start=0, ram_read_addr=0, x1..y2=0, vb_we=0, vb_wr_data=0, scan_reset=1, busy=0, done=0, FSM=IDLE, line counter=0. Asserting reset mid-operation aborts immediately to these values. No in-flight B_Line or ROM2RAM state is tracked after reset.
- State machine:
  - IDLE -> LOAD on start. Sample num_lines; assert busy and scan_reset. load_start pulses on the first cycle of LOAD.
  - LOAD -> FETCH on load_finish.
  - FETCH: drive ram_read_addr = counter and wait RAM_LAT cycles -> LATCH.
  - LATCH: register x1..y2 from ram_read_data1..4 -> DRAW_START.
  - DRAW_START: line_start=1 for exactly one cycle -> DRAW_RUN.
  - DRAW_RUN: vb_we=1 and vb_wr_data=1 every cycle, including the cycle line_finish is seen. On line_finish, go to NEXT.
  - NEXT: increment counter. If counter == num_lines -> SCAN, else -> FETCH.
  - SCAN: scan_reset=0, done=1, busy=0.
- num_lines = 0: LOAD -> SCAN directly; no B_Line start is issued.
- vb_addr is combinational: {line_x, line_y} in DRAW_START and DRAW_RUN, else {pix_x[XW-1:0], pix_y[YW-1:0]}. pix_y is truncated to YW bits.
- start while busy=1 is ignored.
- start in SCAN restarts the sequence: done=0, scan_reset=1 from the next cycle, then go to LOAD.
- line_finish outside DRAW_RUN and load_finish outside LOAD are ignored.
- Counter width is ADDR_W+1 so num_lines = 2^ADDR_W is legal. ram_read_addr takes the low ADDR_W bits of the counter.

Optional Feature:
- Macro: CLEAR_BEFORE_DRAW_EN.
- When defined: a CLEAR state is inserted between LOAD and FETCH. It sweeps vb_addr from 0 to 2^(XW+YW)-1 with vb_we=1 and vb_wr_data=0, one address per cycle, then goes to FETCH. With num_lines=0 it goes to SCAN after the clear. busy stays high throughout.
- When undefined: no CLEAR state; LOAD -> FETCH as above; buffer contents persist between frames.

Decomposition:
- Shared package: FSM state enum (IDLE, LOAD, CLEAR, FETCH, LATCH, DRAW_START, DRAW_RUN, NEXT, SCAN), the XW/YW/ADDR_W defaults, and the buffer-address packing function {x, y}.
- One natural sub-module: vbuf_port_mux. It is the combinational video-buffer address/we/data select, controlled by the FSM's draw/clear/scan selects.

Test Plan:
- Reset low mid-DRAW_RUN (counter=1) -> all outputs at reset values the same cycle; scan_reset=1. After release, FSM is IDLE and ignores line_finish.
- start with num_lines=2, load_finish 7 cycles later -> load_start is one cycle. ram_read_addr=0 then 1; exactly two line_start pulses, each after its LATCH. x1..y2 match RAM words. done=1 and scan_reset=0 one cycle after the second NEXT.
- line_x=5, line_y=3 during DRAW_RUN -> vb_addr=19'h00A03, vb_we=1. In SCAN with pix_x=5, pix_y=3 -> same vb_addr, vb_we=0.
- num_lines=0 -> no line_start; SCAN reached one cycle after load_finish.
- start pulsed in FETCH -> ignored. start pulsed in SCAN -> done falls and scan_reset rises next cycle; a second load_start is issued.
- With CLEAR_BEFORE_DRAW_EN -> exactly 2^19 cycles of vb_we=1, vb_wr_data=0, sequential addresses, before the first FETCH.

Source files
------------

// File: rtl/line_draw_scheduler_pkg.sv
// Shared types and defaults for the line-draw scheduler: FSM states, widths,
// and the {x, y} video-buffer address packing.
package line_draw_scheduler_pkg;

  localparam int LDS_ADDR_W = 8;
  localparam int LDS_XW     = 10;
  localparam int LDS_YW     = 9;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    FETCH,
    LATCH,
    DRAW_START,
    DRAW_RUN,
    NEXT,
    SCAN
  } lds_state_e;

  function automatic logic [LDS_XW+LDS_YW-1:0] pack_vb_addr(
    input logic [LDS_XW-1:0] x,
    input logic [LDS_YW-1:0] y
  );
    return {x, y};
  endfunction

endpackage

// File: rtl/line_draw_scheduler_vbuf_port_mux.sv
// Combinational owner of the single video-buffer port: clear sweep, line-drawer
// writes, or scan-out reads, chosen by the scheduler FSM.
module line_draw_scheduler_vbuf_port_mux
  import line_draw_scheduler_pkg::*;
#(
  parameter int XW = LDS_XW,
  parameter int YW = LDS_YW
) (
  input  logic              clear_sel_i,
  input  logic              draw_sel_i,
  input  logic              draw_wr_i,
  input  logic [XW+YW-1:0]  clr_addr_i,
  input  logic [XW-1:0]     line_x_i,
  input  logic [YW-1:0]     line_y_i,
  input  logic [9:0]        pix_x_i,
  input  logic [9:0]        pix_y_i,
  output logic              vb_we_o,
  output logic [XW+YW-1:0]  vb_addr_o,
  output logic              vb_wr_data_o
);

  // Scan-out counters are wider than the buffer; the high bits are dropped.
  logic unused_pix;
  assign unused_pix = ^{pix_x_i, pix_y_i};

  always_comb begin
    vb_we_o      = 1'b0;
    vb_wr_data_o = 1'b0;
    vb_addr_o    = {pix_x_i[XW-1:0], pix_y_i[YW-1:0]};
    if (clear_sel_i) begin
      vb_we_o   = 1'b1;
      vb_addr_o = clr_addr_i;
    end else if (draw_sel_i) begin
      vb_addr_o    = {line_x_i, line_y_i};
      vb_we_o      = draw_wr_i;
      vb_wr_data_o = draw_wr_i;
    end
  end

endmodule

// File: rtl/line_draw_scheduler.sv
// Frame-build sequencer: ROM2RAM load, per-line fetch/draw via B_Line, then scan-out.
// Optional CLEAR_BEFORE_DRAW_EN inserts a full-buffer clear sweep after the load.
module line_draw_scheduler
  import line_draw_scheduler_pkg::*;
#(
  parameter int ADDR_W  = LDS_ADDR_W,
  parameter int RAM_LAT = 1,
  parameter int XW      = LDS_XW,
  parameter int YW      = LDS_YW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_lines,
  output logic              load_start,
  input  logic              load_finish,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [31:0]       ram_read_data1,
  input  logic [31:0]       ram_read_data2,
  input  logic [31:0]       ram_read_data3,
  input  logic [31:0]       ram_read_data4,
  output logic [31:0]       x1,
  output logic [31:0]       y1,
  output logic [31:0]       x2,
  output logic [31:0]       y2,
  output logic              line_start,
  input  logic              line_finish,
  input  logic [XW-1:0]     line_x,
  input  logic [YW-1:0]     line_y,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic              scan_reset,
  output logic              vb_we,
  output logic [XW+YW-1:0]  vb_addr,
  output logic              vb_wr_data,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  lds_state_e        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   nlines_q, nlines_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              load_start_q;
  logic [31:0]       x1_q, y1_q, x2_q, y2_q;
  logic [XW+YW-1:0]  clr_addr;

`ifdef CLEAR_BEFORE_DRAW_EN
  logic [XW+YW-1:0]  clr_q, clr_d;
  assign clr_addr = clr_q;
`else
  assign clr_addr = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nlines_d = nlines_q;
    lat_d    = lat_q;
`ifdef CLEAR_BEFORE_DRAW_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      // A restart from SCAN behaves exactly like a fresh start from IDLE.
      IDLE, SCAN: begin
        if (start) begin
          state_d  = LOAD;
          nlines_d = num_lines;
          cnt_d    = '0;
        end
      end
      LOAD: begin
        if (load_finish) begin
          lat_d = '0;
`ifdef CLEAR_BEFORE_DRAW_EN
          clr_d   = '0;
          state_d = CLEAR;
`else
          state_d = (nlines_q == '0) ? SCAN : FETCH;
`endif
        end
      end
`ifdef CLEAR_BEFORE_DRAW_EN
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = (nlines_q == '0) ? SCAN : FETCH;
      end
`endif
      FETCH: begin
        if (lat_q == LAT_W'(RAM_LAT - 1)) state_d = LATCH;
        else                              lat_d   = lat_q + 1'b1;
      end
      LATCH:      state_d = DRAW_START;
      DRAW_START: state_d = DRAW_RUN;
      DRAW_RUN:   if (line_finish) state_d = NEXT;
      NEXT: begin
        cnt_d   = cnt_q + 1'b1;
        lat_d   = '0;
        state_d = ((cnt_q + 1'b1) == nlines_q) ? SCAN : FETCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nlines_q     <= '0;
      lat_q        <= '0;
      load_start_q <= 1'b0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
`ifdef CLEAR_BEFORE_DRAW_EN
      clr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nlines_q     <= nlines_d;
      lat_q        <= lat_d;
      load_start_q <= (state_d == LOAD) && (state_q != LOAD);
`ifdef CLEAR_BEFORE_DRAW_EN
      clr_q        <= clr_d;
`endif
      if (state_q == LATCH) begin
        x1_q <= ram_read_data1;
        y1_q <= ram_read_data2;
        x2_q <= ram_read_data3;
        y2_q <= ram_read_data4;
      end
    end
  end

  assign load_start    = load_start_q;
  assign line_start    = (state_q == DRAW_START);
  assign ram_read_addr = cnt_q[ADDR_W-1:0];
  assign x1            = x1_q;
  assign y1            = y1_q;
  assign x2            = x2_q;
  assign y2            = y2_q;
  assign done          = (state_q == SCAN);
  assign scan_reset    = (state_q != SCAN);
  assign busy          = (state_q != IDLE) && (state_q != SCAN);

  line_draw_scheduler_vbuf_port_mux #(
    .XW (XW),
    .YW (YW)
  ) u_vbuf_port_mux (
    .clear_sel_i  (state_q == CLEAR),
    .draw_sel_i   ((state_q == DRAW_START) || (state_q == DRAW_RUN)),
    .draw_wr_i    (state_q == DRAW_RUN),
    .clr_addr_i   (clr_addr),
    .line_x_i     (line_x),
    .line_y_i     (line_y),
    .pix_x_i      (pix_x),
    .pix_y_i      (pix_y),
    .vb_we_o      (vb_we),
    .vb_addr_o    (vb_addr),
    .vb_wr_data_o (vb_wr_data)
  );

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Directed bench for line_draw_scheduler (default build): cycle table for a
// two-line frame plus hand-written reset, restart and scan-address sequences.
module tb_line_draw_scheduler;

  localparam int ADDR_W = 8;
  localparam int XW     = 10;
  localparam int YW     = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_lines = '0;
  logic              load_finish = 1'b0;
  logic              line_finish = 1'b0;
  logic [XW-1:0]     line_x = 10'd5;
  logic [YW-1:0]     line_y = 9'd3;
  logic [9:0]        pix_x = 10'd7;
  logic [9:0]        pix_y = 10'h201;
  logic [31:0]       rd1 = '0, rd2 = '0, rd3 = '0, rd4 = '0;
  logic              load_start, line_start, scan_reset, vb_we, vb_wr_data, busy, done;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [31:0]       x1, y1, x2, y2;
  logic [XW+YW-1:0]  vb_addr;

  int n_pass = 0;
  int n_total = 0;
  int n_line_start = 0;

  // {load_start, line_start, busy, done, scan_reset, vb_we, vb_wr_data}
  localparam logic [6:0] C_RST   = 7'b0000100;
  localparam logic [6:0] C_LOAD1 = 7'b1010100;
  localparam logic [6:0] C_BUSY  = 7'b0010100;
  localparam logic [6:0] C_DS    = 7'b0110100;
  localparam logic [6:0] C_DR    = 7'b0010111;
  localparam logic [6:0] C_SCAN  = 7'b0001000;
  localparam logic [18:0] A_PIX  = 19'h00E01;  // pix_x=7, pix_y=0x201 truncated to 0x001
  localparam logic [18:0] A_DRAW = 19'h00A03;  // line_x=5, line_y=3

  typedef struct {
    logic              st;
    logic              lf;
    logic              lnf;
    logic [6:0]        ctl;
    logic [ADDR_W-1:0] addr;
    logic [18:0]       vba;
  } vec_t;

  vec_t vecs[20];

  line_draw_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_lines      (num_lines),
    .load_start     (load_start),
    .load_finish    (load_finish),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data1 (rd1),
    .ram_read_data2 (rd2),
    .ram_read_data3 (rd3),
    .ram_read_data4 (rd4),
    .x1             (x1),
    .y1             (y1),
    .x2             (x2),
    .y2             (y2),
    .line_start     (line_start),
    .line_finish    (line_finish),
    .line_x         (line_x),
    .line_y         (line_y),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .scan_reset     (scan_reset),
    .vb_we          (vb_we),
    .vb_addr        (vb_addr),
    .vb_wr_data     (vb_wr_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a, input int k);
    return 32'hA000_0000 | (32'(k) << 16) | 32'(a);
  endfunction

  // One-cycle-latency line-table RAM.
  always @(posedge clk) begin
    rd1 <= ram_word(ram_read_addr, 0);
    rd2 <= ram_word(ram_read_addr, 1);
    rd3 <= ram_word(ram_read_addr, 2);
    rd4 <= ram_word(ram_read_addr, 3);
  end

  always @(negedge clk) if (line_start) n_line_start++;

  function automatic vec_t mk(input logic st, input logic lf, input logic lnf,
                              input logic [6:0] ctl, input logic [ADDR_W-1:0] addr,
                              input logic [18:0] vba);
    vec_t v;
    v.st = st; v.lf = lf; v.lnf = lnf; v.ctl = ctl; v.addr = addr; v.vba = vba;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ctl_now();
    return {load_start, line_start, busy, done, scan_reset, vb_we, vb_wr_data};
  endfunction

  task automatic wait_line_start(input string name);
    int k = 0;
    while (line_start !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check(name, 64'(line_start), 64'd1);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, C_LOAD1, 0, A_PIX);
    for (int i = 1; i <= 6; i++) vecs[i] = mk(0, 0, 0, C_BUSY, 0, A_PIX);
    vecs[7]  = mk(0, 1, 0, C_BUSY, 0, A_PIX);   // FETCH line 0
    vecs[8]  = mk(0, 0, 0, C_BUSY, 0, A_PIX);   // LATCH
    vecs[9]  = mk(0, 0, 0, C_DS,   0, A_DRAW);
    vecs[10] = mk(0, 0, 0, C_DR,   0, A_DRAW);
    vecs[11] = mk(0, 0, 0, C_DR,   0, A_DRAW);
    vecs[12] = mk(0, 0, 1, C_BUSY, 0, A_PIX);   // NEXT
    vecs[13] = mk(0, 0, 0, C_BUSY, 1, A_PIX);   // FETCH line 1
    vecs[14] = mk(1, 0, 0, C_BUSY, 1, A_PIX);   // start in FETCH ignored -> LATCH
    vecs[15] = mk(0, 0, 0, C_DS,   1, A_DRAW);
    vecs[16] = mk(0, 0, 0, C_DR,   1, A_DRAW);
    vecs[17] = mk(0, 0, 1, C_BUSY, 1, A_PIX);   // NEXT
    vecs[18] = mk(0, 0, 0, C_SCAN, 2, A_PIX);
    vecs[19] = mk(0, 1, 1, C_SCAN, 2, A_PIX);   // stray finishes ignored

    repeat (3) step();
    check("reset_ctl", 64'(ctl_now()), 64'(C_RST));
    check("reset_addr", 64'(ram_read_addr), 64'd0);
    check("reset_xy", {x1, y1} | {x2, y2}, 64'd0);
    reset = 1'b1;
    step();

    num_lines = 9'd2;
    for (int i = 0; i < 20; i++) begin
      start       = vecs[i].st;
      load_finish = vecs[i].lf;
      line_finish = vecs[i].lnf;
      step();
      check($sformatf("vec%0d_ctl", i), 64'(ctl_now()), 64'(vecs[i].ctl));
      check($sformatf("vec%0d_addr", i), 64'(ram_read_addr), 64'(vecs[i].addr));
      check($sformatf("vec%0d_vbaddr", i), 64'(vb_addr), 64'(vecs[i].vba));
      if (vecs[i].ctl[5]) begin
        check($sformatf("vec%0d_x1y1", i), {x1, y1},
              {ram_word(vecs[i].addr, 0), ram_word(vecs[i].addr, 1)});
        check($sformatf("vec%0d_x2y2", i), {x2, y2},
              {ram_word(vecs[i].addr, 2), ram_word(vecs[i].addr, 3)});
      end
    end
    start = 1'b0; load_finish = 1'b0; line_finish = 1'b0;
    check("line_start_pulses", 64'(n_line_start), 64'd2);

    // Scan-out address path, with pix_y bit 9 dropped.
    pix_x = 10'd5; pix_y = 10'h203;
    #1;
    check("scan_vbaddr", 64'(vb_addr), 64'(A_DRAW));
    check("scan_vbwe", 64'(vb_we), 64'd0);
    pix_x = 10'd7; pix_y = 10'h201;

    // Restart from SCAN with zero lines.
    start = 1'b1; num_lines = 9'd0;
    step();
    start = 1'b0;
    check("restart_ctl", 64'(ctl_now()), 64'(C_LOAD1));
    check("restart_addr", 64'(ram_read_addr), 64'd0);
    step();
    load_finish = 1'b1;
    step();
    load_finish = 1'b0;
    check("zero_lines_scan", 64'(ctl_now()), 64'(C_SCAN));
    step();
    check("zero_lines_no_start", 64'(n_line_start), 64'd2);

    // Abort with reset in the middle of the second line.
    start = 1'b1; num_lines = 9'd3;
    step();
    start = 1'b0; load_finish = 1'b1;
    step();
    load_finish = 1'b0;
    wait_line_start("line0_start_seen");
    step();
    line_finish = 1'b1;
    step();
    line_finish = 1'b0;
    wait_line_start("line1_start_seen");
    step();
    check("mid_run_addr", 64'(ram_read_addr), 64'd1);
    check("mid_run_ctl", 64'(ctl_now()), 64'(C_DR));
    reset = 1'b0;
    #1;
    check("abort_ctl", 64'(ctl_now()), 64'(C_RST));
    check("abort_addr", 64'(ram_read_addr), 64'd0);
    check("abort_xy", {x1, y1} | {x2, y2}, 64'd0);
    step();
    reset = 1'b1;
    line_finish = 1'b1;
    step();
    step();
    line_finish = 1'b0;
    check("idle_ignores_finish", 64'(ctl_now()), 64'(C_RST));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
